// File: rtl/rand_req_arbiter.sv
// rand_req_arbiter: shares one latched-counter random generator among NUM_REQ requesters.
// Ports: clk, resetN (async, active-low); req level requests; rand_in generator dout;
// rise_out registered rising edge to the generator; grant one-hot one-cycle pulse;
// data_out captured value (held); data_valid pulse with grant; busy high outside IDLE.
// Optional feature: define RAND_ARB_PRIORITY_EN for fixed lowest-index priority
// instead of the default round-robin.
module rand_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SIZE_BITS  = 5,
  parameter int GAP_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SIZE_BITS-1:0] rand_in,
  output logic                 rise_out,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SIZE_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, FIRE, CAPTURE, GAP} state_t;
  state_t               state_q, state_d;
  logic [IW-1:0]        winner_q, winner_d, pick;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic                 rise_d, valid_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [SIZE_BITS-1:0] data_d;
`ifndef RAND_ARB_PRIORITY_EN
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [2*NUM_REQ-1:0] rot;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;
  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot = {req, req} >> rr_ptr_q;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) off = IW'(i);
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    pick = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
  end
`else
  always_comb begin
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) pick = IW'(i);
  end
`endif
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    gap_cnt_d = gap_cnt_q;
    grant_d   = '0;
    valid_d   = 1'b0;
    data_d    = data_out;
`ifndef RAND_ARB_PRIORITY_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      IDLE: if (|req) begin
        winner_d = pick;
        state_d  = FIRE;
      end
      FIRE: state_d = CAPTURE;
      CAPTURE: begin
        data_d  = rand_in;
        grant_d = NUM_REQ'(1) << winner_q;
        valid_d = 1'b1;
`ifndef RAND_ARB_PRIORITY_EN
        rr_ptr_d = winner_q == IW'(NUM_REQ - 1) ? '0 : winner_q + 1'b1;
`endif
        if (GAP_CYCLES == 0) state_d = IDLE;
        else begin
          gap_cnt_d = 4'(GAP_CYCLES - 1);
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d   = gap_cnt_q == 4'd0 ? IDLE : GAP;
        gap_cnt_d = gap_cnt_q == 4'd0 ? 4'd0 : gap_cnt_q - 4'd1;
      end
    endcase
    // Registered so rise_out is high exactly during the FIRE cycle.
    rise_d = state_d == FIRE;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      gap_cnt_q  <= '0;
      rise_out   <= 1'b0;
      grant      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
`ifndef RAND_ARB_PRIORITY_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      gap_cnt_q  <= gap_cnt_d;
      rise_out   <= rise_d;
      grant      <= grant_d;
      data_out   <= data_d;
      data_valid <= valid_d;
`ifndef RAND_ARB_PRIORITY_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end
  assign busy = state_q != IDLE;
endmodule
